// File: rtl/bus_pkg.sv
// Shared types for the bus master multiplexer: master count, FSM states and owner index.
package bus_pkg;

    localparam int NUM_MASTERS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [$clog2(NUM_MASTERS)-1:0] owner_t;

endpackage

// File: rtl/onehot_enc4.sv
// Four-bit one-hot to index encoder; onehot flags that exactly one input bit is set.
module onehot_enc4
    import bus_pkg::*;
(
    input  logic [3:0] vec,
    output owner_t     idx,
    output logic       onehot
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        idx    = '0;
        onehot = 1'b0;
        case (vec)
            4'b0001: begin idx = 2'd0; onehot = 1'b1; end
            4'b0010: begin idx = 2'd1; onehot = 1'b1; end
            4'b0100: begin idx = 2'd2; onehot = 1'b1; end
            4'b1000: begin idx = 2'd3; onehot = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/bus_master_mux.sv
// Routes one granted master at a time onto a shared request/ready bus, with
// per-transfer timeout, refusal of overlapping grants and a sticky multi-hot flag.
module bus_master_mux
    import bus_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_MASTERS-1:0]    grant,
    input  logic [NUM_MASTERS*AW-1:0] m_addr,
    input  logic [NUM_MASTERS*DW-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0]    m_we,
    output logic [NUM_MASTERS-1:0]    m_done,
    output logic [NUM_MASTERS-1:0]    m_err,
    output logic [NUM_MASTERS-1:0]    m_drop,
    output logic [DW-1:0]             m_rdata,
    output logic                      bus_valid,
    output logic [AW-1:0]             bus_addr,
    output logic [DW-1:0]             bus_wdata,
    output logic                      bus_we,
    input  logic                      bus_ready,
    input  logic [DW-1:0]             bus_rdata,
    output owner_t                    owner,
    output logic                      busy,
    output logic                      grant_err
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    owner_t                  owner_q, owner_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [DW-1:0]           wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic [DW-1:0]           rdata_q, rdata_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    abort_q, abort_d;
    logic [NUM_MASTERS-1:0]  drop_q, drop_d;
    logic                    gerr_q, gerr_d;

    owner_t                  enc_idx;
    logic                    enc_onehot;
    logic                    grant_multi;
    logic [AW-1:0]           sel_addr;
    logic [DW-1:0]           sel_wdata;
    logic                    sel_we;
    logic [NUM_MASTERS-1:0]  owner_vec;

    onehot_enc4 u_enc (
        .vec    (grant),
        .idx    (enc_idx),
        .onehot (enc_onehot)
    );

    assign grant_multi = (grant != '0) && !enc_onehot;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner_t'(i) == enc_idx) begin
                sel_addr  = m_addr[i*AW +: AW];
                sel_wdata = m_wdata[i*DW +: DW];
                sel_we    = m_we[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        drop_d  = '0;
        gerr_d  = gerr_q | grant_multi;
        case (state_q)
            IDLE: begin
                if (enc_onehot) begin
                    owner_d = enc_idx;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    we_d    = sel_we;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (enc_onehot) drop_d = grant;
                // Ready wins over a timeout landing on the same cycle.
                if (bus_ready) begin
                    rdata_d = bus_rdata;
                    abort_d = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == TO_LAST) begin
                    abort_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                if (enc_onehot) drop_d = grant;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            drop_q  <= '0;
            gerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            drop_q  <= drop_d;
            gerr_q  <= gerr_d;
        end
    end

    assign owner_vec = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << owner_q;

    assign m_done    = (state_q == DONE && !abort_q) ? owner_vec : '0;
    assign m_err     = (state_q == DONE &&  abort_q) ? owner_vec : '0;
    assign m_drop    = drop_q;
    assign m_rdata   = rdata_q;
    assign bus_valid = (state_q == ISSUE);
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_we    = we_q;
    assign owner     = owner_q;
    assign busy      = (state_q != IDLE);
    assign grant_err = gerr_q;

endmodule

// File: tb/tb_bus_master_mux.sv
// Scoreboard bench for bus_master_mux: each transfer pushes its expected response,
// a negedge monitor pops and compares when m_done/m_err fires.
module tb_bus_master_mux;

    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic [1:0]    owner;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          we;
        logic [DW-1:0] rdata;
        logic          err;
    } sb_item_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        grant;
    logic [4*AW-1:0]   m_addr;
    logic [4*DW-1:0]   m_wdata;
    logic [3:0]        m_we;
    logic [3:0]        m_done;
    logic [3:0]        m_err;
    logic [3:0]        m_drop;
    logic [DW-1:0]     m_rdata;
    logic              bus_valid;
    logic [AW-1:0]     bus_addr;
    logic [DW-1:0]     bus_wdata;
    logic              bus_we;
    logic              bus_ready;
    logic [DW-1:0]     bus_rdata;
    logic [1:0]        owner;
    logic              busy;
    logic              grant_err;

    int                n_checks = 0;
    int                n_errors = 0;
    sb_item_t          sb[$];
    sb_item_t          mon_item;
    logic [DW-1:0]     model_rdata;

    bus_master_mux #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .grant     (grant),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_we      (m_we),
        .m_done    (m_done),
        .m_err     (m_err),
        .m_drop    (m_drop),
        .m_rdata   (m_rdata),
        .bus_valid (bus_valid),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata),
        .owner     (owner),
        .busy      (busy),
        .grant_err (grant_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every done/err pulse must match the oldest outstanding transfer.
    always @(negedge clk) begin
        if (!reset && (m_done | m_err) != 4'b0) begin
            check("one_resp", 32'($countones(m_done | m_err)), 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'(m_done | m_err), 32'd0);
            end else begin
                mon_item = sb.pop_front();
                check("m_done",  32'(m_done),  mon_item.err ? 32'd0 : 32'(4'b0001 << mon_item.owner));
                check("m_err",   32'(m_err),   mon_item.err ? 32'(4'b0001 << mon_item.owner) : 32'd0);
                check("m_rdata", 32'(m_rdata), 32'(mon_item.rdata));
                check("owner",   32'(owner),   32'(mon_item.owner));
                check("bus_addr",  32'(bus_addr),  32'(mon_item.addr));
                check("bus_wdata", 32'(bus_wdata), 32'(mon_item.wdata));
                check("bus_we",    32'(bus_we),    32'(mon_item.we));
            end
        end
    end

    // ready_cycle: ISSUE cycle (1-based) with bus_ready high; 0 means never.
    // inj_cycle: ISSUE cycle in which inj_grant is driven; 0 means none.
    task automatic do_xfer(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic we, input int ready_cycle, input logic [DW-1:0] rdata,
                           input int inj_cycle, input logic [3:0] inj_grant);
        sb_item_t   e;
        int         vcount;
        bit         timed;
        int         exp_len;
        logic [3:0] exp_drop;
        timed    = (ready_cycle == 0) || (ready_cycle > TIMEOUT);
        exp_len  = timed ? TIMEOUT : ready_cycle;
        exp_drop = $onehot(inj_grant) ? inj_grant : 4'b0;
        if (!timed) model_rdata = rdata;
        e.owner = 2'(m);
        e.addr  = addr;
        e.wdata = wdata;
        e.we    = we;
        e.rdata = model_rdata;
        e.err   = timed;
        sb.push_back(e);

        m_addr  = (4*AW)'($urandom);
        m_wdata = (4*DW)'($urandom);
        m_we    = 4'($urandom);
        m_addr[m*AW +: AW]  = addr;
        m_wdata[m*DW +: DW] = wdata;
        m_we[m]             = we;

        @(posedge clk); #1 grant = 4'b0001 << m;
        @(posedge clk); #1 grant = 4'b0;
        vcount = 0;
        for (int k = 1; k <= 40; k++) begin
            bus_ready = (k == ready_cycle);
            bus_rdata = (k == ready_cycle) ? rdata : DW'($urandom);
            grant     = (k == inj_cycle) ? inj_grant : 4'b0;
            @(negedge clk);
            if (inj_cycle > 0 && k == inj_cycle + 1) check("m_drop", 32'(m_drop), 32'(exp_drop));
            else if (m_drop != 4'b0) check("no_drop", 32'(m_drop), 32'd0);
            if (!bus_valid) break;
            vcount++;
            if (owner !== 2'(m) || bus_addr !== addr) begin
                check("hold_owner", 32'(owner), 32'(m));
                check("hold_addr", 32'(bus_addr), 32'(addr));
            end
            @(posedge clk); #1;
        end
        bus_ready = 1'b0;
        grant     = 4'b0;
        check("valid_len", 32'(vcount), 32'(exp_len));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; grant = 4'b0; m_addr = '0; m_wdata = '0; m_we = 4'b0;
        bus_ready = 1'b0; bus_rdata = '0; model_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(bus_valid), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_resp",  32'(m_done | m_err | m_drop), 32'd0);
        check("rst_addr",  32'(bus_addr),  32'd0);
        check("rst_rdata", 32'(m_rdata),   32'd0);
        check("rst_gerr",  32'(grant_err), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Directed: basic read, timeout, ready in last cycle, refused grant.
        do_xfer(2, 8'h3C, 8'h11, 1'b0, 3, 8'hA5, 0, 4'b0);
        check("rdata_a5", 32'(m_rdata), 32'hA5);
        do_xfer(0, 8'h40, 8'h22, 1'b1, 0, 8'h77, 0, 4'b0);
        check("rdata_kept", 32'(m_rdata), 32'hA5);
        do_xfer(1, 8'h55, 8'h33, 1'b1, 15, 8'h5A, 0, 4'b0);
        do_xfer(0, 8'h81, 8'h44, 1'b0, 5, 8'hC3, 2, 4'b0010);
        check("gerr_clear", 32'(grant_err), 32'd0);

        // bus_ready while IDLE is ignored.
        bus_ready = 1'b1; bus_rdata = 8'hEE;
        @(posedge clk); #1 bus_ready = 1'b0;
        @(negedge clk);
        check("idle_ready_busy",  32'(busy),    32'd0);
        check("idle_ready_rdata", 32'(m_rdata), 32'(model_rdata));

        // Multi-hot grant in IDLE.
        @(posedge clk); #1 grant = 4'b0011;
        @(posedge clk); #1 grant = 4'b0;
        @(negedge clk);
        check("multi_gerr",  32'(grant_err), 32'd1);
        check("multi_busy",  32'(busy),      32'd0);
        check("multi_valid", 32'(bus_valid), 32'd0);
        check("multi_drop",  32'(m_drop),    32'd0);

        // Multi-hot grant during ISSUE: no drop, transfer completes.
        do_xfer(3, 8'h9E, 8'h66, 1'b1, 4, 8'h3D, 1, 4'b0110);
        check("gerr_sticky", 32'(grant_err), 32'd1);

        // Randomised transfers.
        for (int i = 0; i < 6; i++) begin
            do_xfer(int'($urandom_range(0, 3)), AW'($urandom), DW'($urandom), 1'($urandom),
                    int'($urandom_range(1, TIMEOUT)), DW'($urandom), 0, 4'b0);
        end

        // Reset in the 3rd ISSUE cycle aborts silently.
        m_addr[0 +: AW] = 8'hF0;
        @(posedge clk); #1 grant = 4'b0001;
        @(posedge clk); #1 grant = 4'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        model_rdata = '0;
        @(negedge clk);
        check("abort_valid", 32'(bus_valid), 32'd0);
        check("abort_busy",  32'(busy),      32'd0);
        check("abort_gerr",  32'(grant_err), 32'd0);
        check("abort_rdata", 32'(m_rdata),   32'd0);
        check("abort_owner", 32'(owner),     32'd0);
        repeat (3) @(posedge clk);
        #1;

        do_xfer(1, 8'h12, 8'h34, 1'b0, 2, 8'h9C, 0, 4'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_master_mux.md
BUS_MASTER_MUX -- requirements
Module: bus_master_mux

Interface
REQ-001 Parameters SHALL be, one per line:
  AW, 8, address width.
  DW, 8, data width.
  TIMEOUT, 15, maximum bus_valid cycles before abort (1..255).
REQ-002 Ports SHALL be, one per line, clock and reset first:
  clk  in  1  single clock; all state changes on rising edge.
  reset  in  1  synchronous, active-high reset.
  grant  in  4  one-cycle grant from the upstream bus arbiter, one-hot or zero.
  m_addr  in  4*AW  per-master address, master i at [i*AW +: AW].
  m_wdata  in  4*DW  per-master write data, master i at [i*DW +: DW].
  m_we  in  4  per-master write enable.
  m_done  out  4  one-cycle completion pulse to the owning master.
  m_err  out  4  one-cycle abort (timeout) pulse to the owning master.
  m_drop  out  4  one-cycle pulse: the grant to this master was refused.
  m_rdata  out  DW  read data of the last completed transfer, shared by all masters.
  bus_valid  out  1  shared bus request valid.
  bus_addr  out  AW  shared bus address.
  bus_wdata  out  DW  shared bus write data.
  bus_we  out  1  shared bus write enable.
  bus_ready  in  1  target accepts/completes the request.
  bus_rdata  in  DW  target read data, valid with bus_ready.
  owner  out  2  index of the current bus owner.
  busy  out  1  high in any state other than IDLE.
  grant_err  out  1  sticky flag: a multi-hot grant was seen.

Function
REQ-003 The FSM SHALL have the states IDLE, ISSUE and DONE.
REQ-004 In IDLE, on a one-hot grant at edge N, the block SHALL latch owner, m_addr/m_wdata/m_we of that master into bus_addr/bus_wdata/bus_we, and enter ISSUE; bus_valid SHALL be high from cycle N+1.
REQ-005 bus_addr, bus_wdata, bus_we and owner SHALL hold stable for the whole of ISSUE and DONE.
REQ-006 In ISSUE, bus_ready high at edge M SHALL capture bus_rdata into m_rdata and enter DONE; bus_valid SHALL be low from M+1.
REQ-007 In DONE, m_done[owner] SHALL be high for exactly one cycle, and the FSM SHALL then return to IDLE; a grant is accepted again from the IDLE cycle (M+2).
REQ-008 A timeout counter SHALL clear on entry to ISSUE and increment on each ISSUE cycle without bus_ready; if bus_ready is still low in the TIMEOUT-th ISSUE cycle, the FSM SHALL enter DONE and assert m_err[owner] (not m_done) for that DONE cycle, and m_rdata SHALL remain unchanged.
REQ-009 bus_ready in the same cycle as the timeout SHALL take priority: normal completion, no m_err.
REQ-010 A one-hot grant received in ISSUE or DONE SHALL be refused: m_drop[granted index] high in the next cycle, with no state change.
REQ-011 A multi-hot grant in any state SHALL be ignored (no transfer, no m_drop) and SHALL set grant_err, which stays set until reset.
REQ-012 A zero grant SHALL have no effect.
REQ-013 At most one bit of m_done | m_err SHALL be high in any cycle.
REQ-014 bus_ready in IDLE or DONE SHALL be ignored.

Reset
REQ-015 While reset is high at a clock edge, state SHALL become IDLE, and the block SHALL clear owner, bus_addr, bus_wdata, bus_we, m_rdata, the timeout counter and grant_err to 0, and drive bus_valid, busy, m_done, m_err and m_drop to 0.
REQ-016 Reset in the middle of a transfer SHALL abort it silently: no m_done or m_err pulse, and bus_valid low in the cycle after the reset edge.

Structure
REQ-017 A shared package bus_pkg SHALL hold NUM_MASTERS=4, the FSM state enum (IDLE, ISSUE, DONE) and the owner index type.
REQ-018 A one-hot-to-index encoder SHALL be a sub-module, onehot_enc4, with outputs idx[1:0] and onehot (exactly one bit set).

Verification
REQ-019 Grant 4'b0100, m_addr[2]=0x3C, m_we[2]=0, bus_ready high two cycles after bus_valid rises, bus_rdata=0xA5 -> bus_addr=0x3C, owner=2, m_rdata=0xA5, m_done=4'b0100 for one cycle.
REQ-020 Grant 4'b0001 with bus_ready held low -> bus_valid high for exactly 15 cycles, then m_err=4'b0001 for one cycle, m_done stays 0.
REQ-021 Grant 4'b0001, then grant 4'b0010 while in ISSUE -> m_drop=4'b0010 for one cycle; master 0's transfer completes unaffected.
REQ-022 Grant 4'b0011 in IDLE -> grant_err=1, busy stays 0, no bus_valid.
REQ-023 Reset asserted on the 3rd ISSUE cycle -> bus_valid=0 and busy=0 in the next cycle, no m_done or m_err pulse.
REQ-024 bus_ready asserted in the 15th ISSUE cycle -> m_done pulse, no m_err.
